rx_hdr_sequencer: RTL and testbench
===================================

Name: rx_hdr_sequencer

Overview:
- Sequences the Ethernet header parser in the router-port input path.
- Tracks word position in the 64-bit ingress stream and issues the per-word header strobes (DA_HI, DASA, ETH_IP_VER) to the parser.
- Pops the parser's per-packet result and converts it into one forwarding decision per packet, presented on a valid/ready handshake.
- Applies credit-based backpressure so the parser's 4-entry result FIFO never overflows.

Parameters:
- DATA_WIDTH, 64, stream data width; only 64 is supported.
- CTRL_WIDTH, 8, stream control width (DATA_WIDTH/8).
- NUM_QUEUES, 8, number of router queues; MAC ports sit on even queues.
- NUM_QUEUES_WIDTH, log2(NUM_QUEUES), width of the port-number field.
- MAX_OUTSTANDING, 4, parser result-FIFO depth; the credit limit.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_data  in  64  ingress stream data.
- in_ctrl  in  8  ingress control; 0 = packet data, nonzero on a module-header word or the last packet word.
- in_wr  in  1  ingress word valid.
- in_rdy  out  1  sequencer can accept a new packet's first word.
- word_MAC_DA_HI  out  1  strobe: current word holds DA[47:16] in [63:32].
- word_MAC_DASA  out  1  strobe: current word holds DA[15:0] in [31:16].
- word_ETH_IP_VER  out  1  strobe: current word holds the ethertype in [31:16].
- eth_parser_info_vld  in  1  parser result available.
- eth_parser_rd_info  out  1  pop one parser result.
- is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast  in  1 each  parser result fields.
- mac_dst_port_num  in  NUM_QUEUES_WIDTH  parser matched port.
- dec_vld  out  1  decision valid.
- dec_rdy  in  1  downstream accepts the decision.
- dec_to_cpu  out  1  send to the CPU queue (ARP for us, or broadcast).
- dec_to_lookup  out  1  IP for us, not broadcast; goes to route lookup.
- dec_drop  out  1  neither of the above.
- dec_cpu_queue  out  NUM_QUEUES_WIDTH  mac_dst_port_num+1 (odd CPU queue of the matching port).
- outstanding  out  3  packets strobed but not yet decided (debug).

Behaviour:
- Word FSM states: HDR, WORD0, WORD1, PAYLOAD.
  - Reset: state HDR, all strobes 0.
  - Strobes are combinational, valid only when in_wr=1.
- HDR:
  - Word with in_wr=1 and in_ctrl!=0 is a module header; stay in HDR.
  - First word with in_ctrl==0 is packet word 0. Assert word_MAC_DA_HI and word_MAC_DASA together on that word, then go to WORD1.
- WORD1: next in_wr word gets word_ETH_IP_VER; go to PAYLOAD.
- PAYLOAD: word with in_wr=1 and in_ctrl!=0 is the last word; go to HDR.
- Runt packet: if a nonzero in_ctrl arrives in WORD1, still strobe ETH_IP_VER, then return to HDR. Exactly one parser search per packet.
- WORD0 state is reserved for a skip-one-word header mode; it is unreachable at the 64-bit width.
- Credit counter `outstanding`:
  - +1 on the word_ETH_IP_VER strobe.
  - -1 on an eth_parser_rd_info pulse.
  - Both in the same cycle: no change.
  - Reset value 0. Saturates at MAX_OUTSTANDING; never underflows.
- in_rdy:
  - 0 while in HDR with outstanding==MAX_OUTSTANDING.
  - 1 otherwise, including mid-packet.
  - in_rdy is combinational and does not depend on in_wr.
- Decision FSM states: D_IDLE, D_HOLD.
  - D_IDLE with eth_parser_info_vld=1: pulse eth_parser_rd_info for exactly 1 cycle, register the fields, go to D_HOLD.
  - D_HOLD: dec_vld=1 and outputs held stable until dec_rdy=1, then return to D_IDLE.
  - Throughput: at most one decision every 2 cycles. No pop while D_HOLD.
- Decision encoding:
  - to_cpu = for_us & (arp | broadcast).
  - to_lookup = for_us & ip & !broadcast & !arp.
  - drop = !(to_cpu | to_lookup).
  - Exactly one is set while dec_vld=1.
  - dec_cpu_queue wraps modulo 2^NUM_QUEUES_WIDTH.
- Reset values: all dec_* outputs 0, eth_parser_rd_info 0, outstanding 0, in_rdy 1.
- Reset mid-packet: FSMs return to HDR/D_IDLE. The parser is reset by the same signal, so no stale credit remains.
- Sim check: error and $stop if eth_parser_info_vld=0 while outstanding==0 at a pop, or if in_wr=1 while in_rdy=0 at a packet start.

Decomposition:
- Shared package/header: ETH_ARP=16'h0806, ETH_IP=16'h0800, the word-FSM and decision-FSM state encodings, MAX_OUTSTANDING.
- One natural sub-module, rx_credit_counter: up/down saturating counter with a full flag, reusable by other header parsers.

Test Plan:
- 1 module header + 8-word IP packet, DA=our mac_0, parser returns for_us=1, ip=1, port=0 -> DA_HI/DASA on word index 1, ETH_IP_VER on index 2, one rd_info pulse, dec_to_lookup=1, dec_cpu_queue=1.
- ARP broadcast frame, parser returns for_us=1, arp=1, broadcast=1, port=6 -> dec_to_cpu=1, dec_cpu_queue=7.
- Five back-to-back 3-word packets with the parser result withheld -> in_rdy=0 before the 5th packet's first word, outstanding=4; release one result -> in_rdy=1 the next cycle.
- dec_rdy held low for 10 cycles -> dec_* stable for 10 cycles, no further rd_info pulses; dec_rdy=1 -> next decision after 2 cycles.
- 2-word runt (last word at WORD1) -> ETH_IP_VER still strobed once, FSM back in HDR, next packet's strobes correct.
- Reset asserted during PAYLOAD with outstanding=2 -> outstanding=0, dec_vld=0, in_rdy=1; the following packet is sequenced normally.

Source files
------------

// File: rtl/rx_hdr_sequencer_pkg.sv
// Shared constants and state encodings for the Ethernet header sequencer.
package rx_hdr_sequencer_pkg;
  localparam logic [15:0] ETH_ARP = 16'h0806;
  localparam logic [15:0] ETH_IP  = 16'h0800;

  localparam int MAX_OUTSTANDING   = 4;
  localparam int OUTSTANDING_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  // WORD0 is kept for a skip-one-word header mode used at narrower widths.
  typedef enum logic [1:0] {HDR, WORD0, WORD1, PAYLOAD} word_state_t;
  typedef enum logic {D_IDLE, D_HOLD} dec_state_t;
endpackage

// File: rtl/rx_credit_counter.sv
// Up/down saturating credit counter with a full flag; simultaneous inc/dec cancel.
module rx_credit_counter #(
  parameter int MAX   = 4,
  parameter int WIDTH = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             full
);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && count != MAX_CNT) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign full = (count == MAX_CNT);
endmodule

// File: rtl/rx_hdr_sequencer.sv
// Issues per-word header strobes to the Ethernet parser, throttles packet starts on
// parser credits, and turns each parser result into one held forwarding decision.
module rx_hdr_sequencer
  import rx_hdr_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH       = 64,
  parameter int CTRL_WIDTH       = DATA_WIDTH / 8,
  parameter int NUM_QUEUES       = 8,
  parameter int NUM_QUEUES_WIDTH = $clog2(NUM_QUEUES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [CTRL_WIDTH-1:0]       in_ctrl,
  input  logic                        in_wr,
  output logic                        in_rdy,
  output logic                        word_MAC_DA_HI,
  output logic                        word_MAC_DASA,
  output logic                        word_ETH_IP_VER,
  input  logic                        eth_parser_info_vld,
  output logic                        eth_parser_rd_info,
  input  logic                        is_for_us,
  input  logic                        is_arp_pkt,
  input  logic                        is_ip_pkt,
  input  logic                        is_broadcast,
  input  logic [NUM_QUEUES_WIDTH-1:0] mac_dst_port_num,
  output logic                        dec_vld,
  input  logic                        dec_rdy,
  output logic                        dec_to_cpu,
  output logic                        dec_to_lookup,
  output logic                        dec_drop,
  output logic [NUM_QUEUES_WIDTH-1:0] dec_cpu_queue,
  output logic [2:0]                  outstanding
);
  word_state_t state, state_next;
  dec_state_t  dstate, dstate_next;

  logic [OUTSTANDING_WIDTH-1:0] credit_count;
  logic                         credit_full;
  logic                         to_cpu_q, to_lookup_q;
  logic [NUM_QUEUES_WIDTH-1:0]  cpu_queue_q;
  logic                         unused_data;

  // Header fields are extracted by the parser itself; only framing is used here.
  assign unused_data = ^in_data;

  rx_credit_counter #(
    .MAX   (MAX_OUTSTANDING),
    .WIDTH (OUTSTANDING_WIDTH)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .inc   (word_ETH_IP_VER),
    .dec   (eth_parser_rd_info),
    .count (credit_count),
    .full  (credit_full)
  );

  assign outstanding = 3'(credit_count);
  assign in_rdy      = !((state == HDR) && credit_full);

  always_ff @(posedge clk) begin
    if (reset) state <= HDR;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    word_MAC_DA_HI  = 1'b0;
    word_MAC_DASA   = 1'b0;
    word_ETH_IP_VER = 1'b0;
    if (in_wr) begin
      case (state)
        HDR: begin
          if (in_ctrl == '0) begin
            word_MAC_DA_HI = 1'b1;
            word_MAC_DASA  = 1'b1;
            state_next     = WORD1;
          end
        end
        WORD0: begin
          word_MAC_DASA = 1'b1;
          state_next    = WORD1;
        end
        // A runt ending here still gets its single parser search.
        WORD1: begin
          word_ETH_IP_VER = 1'b1;
          state_next      = (in_ctrl != '0) ? HDR : PAYLOAD;
        end
        PAYLOAD: begin
          if (in_ctrl != '0) state_next = HDR;
        end
        default: state_next = HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) dstate <= D_IDLE;
    else       dstate <= dstate_next;
  end

  always_comb begin
    dstate_next        = dstate;
    eth_parser_rd_info = 1'b0;
    case (dstate)
      D_IDLE: begin
        if (eth_parser_info_vld) begin
          eth_parser_rd_info = 1'b1;
          dstate_next        = D_HOLD;
        end
      end
      D_HOLD: begin
        if (dec_rdy) dstate_next = D_IDLE;
      end
      default: dstate_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cpu_q    <= 1'b0;
      to_lookup_q <= 1'b0;
      cpu_queue_q <= '0;
    end else if (eth_parser_rd_info) begin
      to_cpu_q    <= is_for_us && (is_arp_pkt || is_broadcast);
      to_lookup_q <= is_for_us && is_ip_pkt && !is_broadcast && !is_arp_pkt;
      cpu_queue_q <= mac_dst_port_num + NUM_QUEUES_WIDTH'(1);
    end
  end

  // Decision fields read as zero whenever no decision is being offered.
  assign dec_vld       = (dstate == D_HOLD);
  assign dec_to_cpu    = dec_vld && to_cpu_q;
  assign dec_to_lookup = dec_vld && to_lookup_q;
  assign dec_drop      = dec_vld && !(to_cpu_q || to_lookup_q);
  assign dec_cpu_queue = dec_vld ? cpu_queue_q : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(eth_parser_rd_info && !eth_parser_info_vld && credit_count == '0))
        else $error("rx_hdr_sequencer: parser pop with no result available");
      assert (!(in_wr && !in_rdy && in_ctrl == '0))
        else $error("rx_hdr_sequencer: packet start while not ready");
    end
  end
endmodule

// File: tb/tb_rx_hdr_sequencer.sv
// Directed bench for rx_hdr_sequencer: strobes, credits, decisions, stall, runt, reset.
module tb_rx_hdr_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic        word_MAC_DA_HI, word_MAC_DASA, word_ETH_IP_VER;
  logic        eth_parser_info_vld, eth_parser_rd_info;
  logic        is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast;
  logic [2:0]  mac_dst_port_num;
  logic        dec_vld, dec_rdy, dec_to_cpu, dec_to_lookup, dec_drop;
  logic [2:0]  dec_cpu_queue;
  logic [2:0]  outstanding;

  int vectors = 0;
  int miscompares = 0;

  rx_hdr_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .in_data             (in_data),
    .in_ctrl             (in_ctrl),
    .in_wr               (in_wr),
    .in_rdy              (in_rdy),
    .word_MAC_DA_HI      (word_MAC_DA_HI),
    .word_MAC_DASA       (word_MAC_DASA),
    .word_ETH_IP_VER     (word_ETH_IP_VER),
    .eth_parser_info_vld (eth_parser_info_vld),
    .eth_parser_rd_info  (eth_parser_rd_info),
    .is_for_us           (is_for_us),
    .is_arp_pkt          (is_arp_pkt),
    .is_ip_pkt           (is_ip_pkt),
    .is_broadcast        (is_broadcast),
    .mac_dst_port_num    (mac_dst_port_num),
    .dec_vld             (dec_vld),
    .dec_rdy             (dec_rdy),
    .dec_to_cpu          (dec_to_cpu),
    .dec_to_lookup       (dec_to_lookup),
    .dec_drop            (dec_drop),
    .dec_cpu_queue       (dec_cpu_queue),
    .outstanding         (outstanding)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [7:0] ctrl, input logic [63:0] data,
                            output logic [2:0] strb, output logic rdy);
    cycle();
    in_wr   = 1'b1;
    in_ctrl = ctrl;
    in_data = data;
    #1;
    strb = {word_MAC_DA_HI, word_MAC_DASA, word_ETH_IP_VER};
    rdy  = in_rdy;
  endtask

  task automatic idle();
    cycle();
    in_wr   = 1'b0;
    in_ctrl = 8'h00;
  endtask

  task automatic pop_result(input logic fu, input logic arp, input logic ip, input logic bc,
                            input logic [2:0] port, output logic rd);
    cycle();
    is_for_us           = fu;
    is_arp_pkt          = arp;
    is_ip_pkt           = ip;
    is_broadcast        = bc;
    mac_dst_port_num    = port;
    eth_parser_info_vld = 1'b1;
    #1;
    rd = eth_parser_rd_info;
    cycle();
    eth_parser_info_vld = 1'b0;
    #1;
  endtask

  task automatic release_dec();
    dec_rdy = 1'b1;
    cycle();
    dec_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    vectors++;
    if ({word_MAC_DA_HI, word_MAC_DASA, word_ETH_IP_VER} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 000", {word_MAC_DA_HI, word_MAC_DASA, word_ETH_IP_VER});
    end
    vectors++;
    if ({dec_vld, dec_to_cpu, dec_to_lookup, dec_drop, dec_cpu_queue, eth_parser_rd_info} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_dec: got %b expected 00000000",
               {dec_vld, dec_to_cpu, dec_to_lookup, dec_drop, dec_cpu_queue, eth_parser_rd_info});
    end
    vectors++;
    if (outstanding !== 3'd0 || in_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_credit: got outstanding=%0d in_rdy=%b expected 0/1", outstanding, in_rdy);
    end
    reset = 1'b0;
  endtask

  task automatic test_ip_packet();
    logic [7:0] ctrl_tab [9];
    logic [2:0] exp_tab [9];
    logic [2:0] strb;
    logic       rdy, rd;
    ctrl_tab = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    exp_tab  = '{3'b000, 3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 9; i++) begin
      drive_word(ctrl_tab[i], 64'h0012_3456_789A_0000 + 64'(i), strb, rdy);
      vectors++;
      if (strb !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL ip_strobe[%0d]: got %b expected %b", i, strb, exp_tab[i]);
      end
    end
    idle();
    #1;
    vectors++;
    if (outstanding !== 3'd1) begin
      miscompares++;
      $display("FAIL ip_outstanding: got %0d expected 1", outstanding);
    end
    pop_result(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, rd);
    vectors++;
    if (rd !== 1'b1) begin
      miscompares++;
      $display("FAIL ip_rd_info: got %b expected 1", rd);
    end
    vectors++;
    if ({dec_vld, dec_to_cpu, dec_to_lookup, dec_drop, dec_cpu_queue} !== 7'b1010_001) begin
      miscompares++;
      $display("FAIL ip_decision: got %b expected 1010001",
               {dec_vld, dec_to_cpu, dec_to_lookup, dec_drop, dec_cpu_queue});
    end
    vectors++;
    if (outstanding !== 3'd0 || eth_parser_rd_info !== 1'b0) begin
      miscompares++;
      $display("FAIL ip_after_pop: got outstanding=%0d rd_info=%b expected 0/0", outstanding, eth_parser_rd_info);
    end
    release_dec();
    #1;
    vectors++;
    if (dec_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL ip_release: got dec_vld=%b expected 0", dec_vld);
    end
  endtask

  task automatic test_arp_broadcast();
    logic [2:0] strb;
    logic       rdy, rd;
    drive_word(8'h00, 64'hFFFF_FFFF_FFFF_0000, strb, rdy);
    drive_word(8'h00, 64'h0000_0000_0806_0001, strb, rdy);
    drive_word(8'h80, 64'h0, strb, rdy);
    idle();
    pop_result(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, rd);
    vectors++;
    if ({dec_vld, dec_to_cpu, dec_to_lookup, dec_drop, dec_cpu_queue} !== 7'b1100_111) begin
      miscompares++;
      $display("FAIL arp_decision: got %b expected 1100111",
               {dec_vld, dec_to_cpu, dec_to_lookup, dec_drop, dec_cpu_queue});
    end
    release_dec();
  endtask

  task automatic test_encoding();
    logic [7:0] in_tab  [4];
    logic [5:0] exp_tab [4];
    logic       rd;
    // {for_us, arp, ip, bcast, 1'b0, port} -> {cpu, lookup, drop, queue}
    in_tab  = '{8'b0101_0010, 8'b1011_0111, 8'b1110_0100, 8'b1000_0011};
    exp_tab = '{6'b001_011, 6'b100_000, 6'b100_101, 6'b001_100};
    for (int i = 0; i < 4; i++) begin
      pop_result(in_tab[i][7], in_tab[i][6], in_tab[i][5], in_tab[i][4], in_tab[i][2:0], rd);
      vectors++;
      if ({dec_to_cpu, dec_to_lookup, dec_drop, dec_cpu_queue} !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL encoding[%0d]: got %b expected %b", i,
                 {dec_to_cpu, dec_to_lookup, dec_drop, dec_cpu_queue}, exp_tab[i]);
      end
      release_dec();
    end
    #1;
    vectors++;
    if (outstanding !== 3'd0) begin
      miscompares++;
      $display("FAIL encoding_no_underflow: got %0d expected 0", outstanding);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] strb;
    logic       rdy, rd;
    for (int i = 0; i < 12; i++) begin
      drive_word((i % 3 == 2) ? 8'h80 : 8'h00, 64'(i), strb, rdy);
      vectors++;
      if (strb !== ((i % 3 == 0) ? 3'b110 : (i % 3 == 1) ? 3'b001 : 3'b000) || rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_word[%0d]: got strb=%b rdy=%b", i, strb, rdy);
      end
    end
    idle();
    #1;
    vectors++;
    if (in_rdy !== 1'b0 || outstanding !== 3'd4) begin
      miscompares++;
      $display("FAIL b2b_full: got in_rdy=%b outstanding=%0d expected 0/4", in_rdy, outstanding);
    end
    cycle();
    {is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast} = 4'b0010;
    mac_dst_port_num    = 3'd5;
    eth_parser_info_vld = 1'b1;
    #1;
    vectors++;
    if (eth_parser_rd_info !== 1'b1 || in_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_release_pop: got rd_info=%b in_rdy=%b expected 1/0", eth_parser_rd_info, in_rdy);
    end
    cycle();
    eth_parser_info_vld = 1'b0;
    #1;
    vectors++;
    if (in_rdy !== 1'b1 || outstanding !== 3'd3 || dec_drop !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_release: got in_rdy=%b outstanding=%0d drop=%b expected 1/3/1", in_rdy, outstanding, dec_drop);
    end
    for (int i = 0; i < 3; i++) begin
      drive_word((i == 2) ? 8'h80 : 8'h00, 64'(i), strb, rdy);
      vectors++;
      if (strb !== ((i == 0) ? 3'b110 : (i == 1) ? 3'b001 : 3'b000)) begin
        miscompares++;
        $display("FAIL b2b_fifth[%0d]: got %b", i, strb);
      end
    end
    idle();
    #1;
    vectors++;
    if (outstanding !== 3'd4) begin
      miscompares++;
      $display("FAIL b2b_fifth_credit: got %0d expected 4", outstanding);
    end
  endtask

  task automatic test_dec_stall();
    logic rd;
    {is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast} = 4'b1010;
    mac_dst_port_num    = 3'd2;
    eth_parser_info_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      vectors++;
      if ({dec_vld, dec_to_cpu, dec_to_lookup, dec_drop, dec_cpu_queue, eth_parser_rd_info} !== 8'b1001_1100) begin
        miscompares++;
        $display("FAIL stall[%0d]: got %b expected 10011100", i,
                 {dec_vld, dec_to_cpu, dec_to_lookup, dec_drop, dec_cpu_queue, eth_parser_rd_info});
      end
    end
    release_dec();
    #1;
    vectors++;
    if (dec_vld !== 1'b0 || eth_parser_rd_info !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_idle: got dec_vld=%b rd_info=%b expected 0/1", dec_vld, eth_parser_rd_info);
    end
    cycle();
    eth_parser_info_vld = 1'b0;
    #1;
    vectors++;
    if ({dec_vld, dec_to_lookup, dec_cpu_queue} !== 5'b11_011 || outstanding !== 3'd3) begin
      miscompares++;
      $display("FAIL stall_next: got vld/lookup/queue=%b outstanding=%0d expected 11011/3",
               {dec_vld, dec_to_lookup, dec_cpu_queue}, outstanding);
    end
    release_dec();
    for (int i = 0; i < 3; i++) begin
      pop_result(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, rd);
      release_dec();
    end
    #1;
    vectors++;
    if (outstanding !== 3'd0) begin
      miscompares++;
      $display("FAIL stall_drain: got %0d expected 0", outstanding);
    end
  endtask

  task automatic test_runt();
    logic [2:0] strb;
    logic       rdy, rd;
    drive_word(8'h00, 64'h1, strb, rdy);
    vectors++;
    if (strb !== 3'b110) begin
      miscompares++;
      $display("FAIL runt_w0: got %b expected 110", strb);
    end
    drive_word(8'hC0, 64'h2, strb, rdy);
    vectors++;
    if (strb !== 3'b001) begin
      miscompares++;
      $display("FAIL runt_w1: got %b expected 001", strb);
    end
    for (int i = 0; i < 3; i++) begin
      drive_word((i == 2) ? 8'h80 : 8'h00, 64'(i), strb, rdy);
      vectors++;
      if (strb !== ((i == 0) ? 3'b110 : (i == 1) ? 3'b001 : 3'b000)) begin
        miscompares++;
        $display("FAIL runt_next[%0d]: got %b", i, strb);
      end
    end
    idle();
    #1;
    vectors++;
    if (outstanding !== 3'd2) begin
      miscompares++;
      $display("FAIL runt_credit: got %0d expected 2", outstanding);
    end
    pop_result(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, rd);
  endtask

  task automatic test_reset_midpacket();
    logic [2:0] strb;
    logic       rdy, rd;
    for (int i = 0; i < 3; i++) drive_word(8'h00, 64'(i), strb, rdy);
    vectors++;
    if (outstanding !== 3'd2 || dec_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL midpkt_setup: got outstanding=%0d dec_vld=%b expected 2/1", outstanding, dec_vld);
    end
    reset = 1'b1;
    in_wr = 1'b0;
    cycle();
    reset = 1'b0;
    #1;
    vectors++;
    if (outstanding !== 3'd0 || dec_vld !== 1'b0 || in_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL midpkt_reset: got outstanding=%0d dec_vld=%b in_rdy=%b expected 0/0/1",
               outstanding, dec_vld, in_rdy);
    end
    for (int i = 0; i < 3; i++) begin
      drive_word((i == 2) ? 8'h80 : 8'h00, 64'(i), strb, rdy);
      vectors++;
      if (strb !== ((i == 0) ? 3'b110 : (i == 1) ? 3'b001 : 3'b000)) begin
        miscompares++;
        $display("FAIL midpkt_next[%0d]: got %b", i, strb);
      end
    end
    idle();
    pop_result(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, rd);
    vectors++;
    if ({dec_to_lookup, dec_cpu_queue} !== 4'b1_010 || outstanding !== 3'd0) begin
      miscompares++;
      $display("FAIL midpkt_decision: got lookup/queue=%b outstanding=%0d expected 1010/0",
               {dec_to_lookup, dec_cpu_queue}, outstanding);
    end
    release_dec();
  endtask

  initial begin
    reset               = 1'b1;
    in_data             = '0;
    in_ctrl             = '0;
    in_wr               = 1'b0;
    eth_parser_info_vld = 1'b0;
    is_for_us           = 1'b0;
    is_arp_pkt          = 1'b0;
    is_ip_pkt           = 1'b0;
    is_broadcast        = 1'b0;
    mac_dst_port_num    = '0;
    dec_rdy             = 1'b0;
    test_reset();
    test_ip_packet();
    test_arp_broadcast();
    test_encoding();
    test_back_to_back();
    test_dec_stall();
    test_runt();
    test_reset_midpacket();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
